// File: rtl/strided_buffer_feeder.sv
// Strided DDR burst feeder: issues credit-gated burst read requests at a
// fixed stride and forwards returned beats into a local buffer.
module strided_buffer_feeder #(
   parameter int DATA_WIDTH  = 64,
   parameter int B_ADDR      = 32,
   parameter int UNIT_BURSTS = 32,
   parameter int N_CREDIT    = 8,
   parameter int B_NBURST    = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [B_ADDR-1:0]     base_addr,
   input  logic [B_NBURST-1:0]   n_bursts,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic [B_ADDR-1:0]     req_addr,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic                  wr_en,
   output logic [DATA_WIDTH-1:0] wr_di,
   input  logic                  credit_rtn
);

   localparam int BW = (UNIT_BURSTS > 1) ? $clog2(UNIT_BURSTS) : 1;
   localparam int CW = $clog2(N_CREDIT + 1);
   localparam logic [B_ADDR-1:0] STRIDE =
      B_ADDR'(UNIT_BURSTS * DATA_WIDTH / 8);
   localparam logic [BW-1:0] LAST_BEAT = BW'(UNIT_BURSTS - 1);
   localparam logic [CW-1:0] CMAX      = CW'(N_CREDIT);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [CW-1:0]         r_credits;
   logic [B_NBURST-1:0]   r_nbursts;
   logic [B_NBURST-1:0]   r_issued;
   logic [B_NBURST-1:0]   r_received;
   logic [BW-1:0]         r_beat;
   logic [B_ADDR-1:0]     r_addr;
   logic                  r_err;
   logic                  r_wr_en;
   logic [DATA_WIDTH-1:0] r_wr_di;

   logic w_start_acc;
   logic w_req_hs;
   logic w_beat_acc;
   logic w_beat_last;

   assign w_start_acc = start & (r_state == IDLE);
   assign w_req_hs    = req_valid & req_ready;
   assign w_beat_acc  = s_valid & s_ready;
   assign w_beat_last = (r_beat == LAST_BEAT);

   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);
   assign s_ready   = (r_state == RUN);
   assign req_valid = (r_state == RUN) && (r_credits != '0) &&
                      (r_issued < r_nbursts);
   assign req_addr  = r_addr;
   assign err       = r_err;
   assign wr_en     = r_wr_en;
   assign wr_di     = r_wr_di;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // The last beat's write is emitted in the cycle received reaches the
   // target, so leaving RUN here never drops a pending write.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (r_received == r_nbursts) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Credits track buffer space independently of the job state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_credits <= CMAX;
      end else if (w_req_hs && !credit_rtn) begin
         r_credits <= r_credits - CW'(1);
      end else if (!w_req_hs && credit_rtn && r_credits != CMAX) begin
         r_credits <= r_credits + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_nbursts  <= '0;
         r_issued   <= '0;
         r_addr     <= '0;
      end else if (w_start_acc) begin
         r_nbursts  <= n_bursts;
         r_issued   <= '0;
         r_addr     <= base_addr;
      end else if (w_req_hs) begin
         r_issued   <= r_issued + B_NBURST'(1);
         r_addr     <= r_addr + STRIDE;
      end
   end

   // Framing is judged against the beat counter; s_last never resyncs it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_received <= '0;
         r_beat     <= '0;
         r_err      <= 1'b0;
      end else if (w_start_acc) begin
         r_received <= '0;
         r_beat     <= '0;
         r_err      <= 1'b0;
      end else if (w_beat_acc) begin
         if (s_last != w_beat_last) r_err <= 1'b1;
         if (w_beat_last) begin
            r_beat     <= '0;
            r_received <= r_received + B_NBURST'(1);
         end else begin
            r_beat     <= r_beat + BW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_en <= 1'b0;
         r_wr_di <= '0;
      end else begin
         r_wr_en <= w_beat_acc;
         if (w_beat_acc) r_wr_di <= s_data;
      end
   end

endmodule

// File: doc/strided_buffer_feeder.md
STRIDED_BUFFER_FEEDER -- requirements
Module: strided_buffer_feeder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DATA_WIDTH 64 beat width, matches buffer write data;
  B_ADDR 32 DDR byte-address width;
  UNIT_BURSTS 32 beats per burst, power of 2;
  N_CREDIT 8 bursts the buffer holds;
  B_NBURST 16 width of burst-count field.
REQ-002 Ports (name direction width meaning), one per line; clock and reset listed first:
  clk in 1 sole clock;
  rstn in 1 reset, asynchronous, active-low;
  start in 1 job start pulse;
  base_addr in B_ADDR job DDR start address;
  n_bursts in B_NBURST bursts in job;
  busy out 1 job active;
  done out 1 one-cycle job-complete pulse;
  err out 1 sticky burst-framing error;
  req_valid out 1 burst read request valid;
  req_ready in 1 request accepted;
  req_addr out B_ADDR burst start address;
  s_valid in 1 return beat valid;
  s_ready out 1 return beat accepted;
  s_data in DATA_WIDTH return beat data;
  s_last in 1 return beat is last of burst;
  wr_en out 1 buffer write strobe;
  wr_di out DATA_WIDTH buffer write data;
  credit_rtn in 1 one burst freed by buffer reader.
REQ-003 The block SHALL use one clock (clk) and an asynchronous active-low reset (rstn).

Function
REQ-004 FSM states SHALL be IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE when all n_bursts bursts are received and the final wr_en is emitted; DONE->IDLE after exactly 1 cycle.
REQ-005 start SHALL be ignored outside IDLE; on acceptance, base_addr and n_bursts SHALL be latched and err cleared.
REQ-006 A start with n_bursts==0 SHALL go RUN->DONE on the next cycle, issue no request and raise no wr_en.
REQ-007 busy SHALL be 1 in RUN and DONE; done SHALL be 1 only in DONE.
REQ-008 Credit counter range SHALL be 0..N_CREDIT:
  request handshake (req_valid & req_ready) decrements it;
  credit_rtn increments it;
  both in the same cycle leave it unchanged;
  credit_rtn at N_CREDIT is ignored, saturating;
  counting continues in every state.
REQ-009 req_valid SHALL assert in RUN only when credits>0 and issued<n_bursts.
REQ-010 req_addr SHALL equal base_addr + issued*UNIT_BURSTS*DATA_WIDTH/8, modulo 2^B_ADDR, wrapping silently.
REQ-011 Once asserted, req_valid and req_addr SHALL hold stable until req_ready; issued SHALL increment on each handshake.
REQ-012 s_ready SHALL be 1 in RUN and 0 otherwise.
REQ-013 Each accepted beat SHALL produce wr_en=1 with wr_di=s_data exactly 1 cycle later (registered, no backpressure from the buffer).
REQ-014 Beat counter SHALL count 0..UNIT_BURSTS-1, wrap to 0 and increment received bursts on wrap.
REQ-015 s_last SHALL be checked on every accepted beat:
  s_last=1 at beat!=UNIT_BURSTS-1 sets err;
  s_last=0 at beat==UNIT_BURSTS-1 sets err;
  framing follows the counter, not s_last;
  err stays set until the next accepted start or reset.

Reset
REQ-016 While rstn=0, outputs SHALL be: busy, done, err, req_valid, s_ready and wr_en 0; req_addr and wr_di 0; state IDLE; credits N_CREDIT; issued, received and beat counters 0.
REQ-017 Reset asserted mid-job SHALL abandon the job with no done pulse; the next start begins a fresh job.

Verification
REQ-018 Scenario: n_bursts=3, base 0x1000, req_ready=1, stream 96 beats with correct s_last -> req_addr 0x1000/0x1100/0x1200, 96 wr_en each 1 cycle after its beat, one done pulse, err=0.
REQ-019 Scenario: N_CREDIT=8, n_bursts=10, no credit_rtn -> exactly 8 requests, then req_valid=0; two credit_rtn pulses -> requests 9 and 10 issue.
REQ-020 Scenario: credit_rtn coincides with a request handshake at credits=1 -> credits remain 1; credit_rtn at credits=8 -> credits stay 8.
REQ-021 Scenario: base 0xFFFFFF00, n_bursts=2 -> req_addr 0xFFFFFF00 then 0x00000000.
REQ-022 Scenario: s_last=1 on beat 5 -> err=1; job still completes after 32*n_bursts beats; err clears on next start.
REQ-023 Scenario: rstn pulsed low mid-RUN, then start with n_bursts=0 -> all outputs 0 during reset; no done for the aborted job; done pulses 2 cycles after the new start.
